// File: rtl/led_display_row_scheduler.sv
// led_display_row_scheduler: fetches one row pair per scan line, hands it to the shift driver, then blanks and lights the panel.
// Ports: clk_in/reset_in clock and sync active-high reset; enable_in scan enable; brightness_in on-time in cycles;
// fb_rd_* frame-buffer read request/response; row_valid_out/row_out/row_ready_in/latch_in shift-driver handshake;
// row_addr_out panel address lines; oe_n_out panel output enable (active low); frame_done_out end-of-frame pulse.
module led_display_row_scheduler #(
    parameter int NUM_ROW_ADDR = 16,
    parameter int ROW_ADDR_W = $clog2(NUM_ROW_ADDR),
    parameter int BLANK_CYCLES = 4,
    parameter int ROW_W = 384
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  enable_in,
    input  logic [7:0]            brightness_in,
    output logic                  fb_rd_req_out,
    output logic [ROW_ADDR_W-1:0] fb_rd_addr_out,
    input  logic                  fb_rd_valid_in,
    input  logic [ROW_W-1:0]      fb_rd_data_in,
    output logic                  row_valid_out,
    output logic [ROW_W-1:0]      row_out,
    input  logic                  row_ready_in,
    input  logic                  latch_in,
    output logic [ROW_ADDR_W-1:0] row_addr_out,
    output logic                  oe_n_out,
    output logic                  frame_done_out
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, SEND, WAIT_LATCH, BLANK, DISPLAY} state_t;
    localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES - 1);
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(NUM_ROW_ADDR - 1);
    state_t state_q, state_d;
    logic [ROW_ADDR_W-1:0] row_ptr_q, row_ptr_d, row_addr_q, row_addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_buf_q, row_buf_d;
    logic oe_n_q, oe_n_d, frame_done_q, frame_done_d;
    logic advance, wrap;
    always_comb begin
        state_d = state_q;
        row_ptr_d = row_ptr_q;
        row_addr_d = row_addr_q;
        cnt_d = cnt_q;
        row_buf_d = row_buf_q;
        frame_done_d = 1'b0;
        advance = 1'b0;
        wrap = row_ptr_q == LAST_ROW;
        case (state_q)
            IDLE: state_d = enable_in ? FETCH : IDLE;
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: if (fb_rd_valid_in) begin
                row_buf_d = fb_rd_data_in;
                state_d = SEND;
            end
            SEND: state_d = row_ready_in ? WAIT_LATCH : SEND;
            WAIT_LATCH: if (latch_in) begin
                state_d = BLANK;
                row_addr_d = row_ptr_q;
                cnt_d = BLANK_INIT;
            end
            BLANK: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else if (brightness_in != 8'd0) begin
                    state_d = DISPLAY;
                    cnt_d = brightness_in - 8'd1;
                end else advance = 1'b1;
            DISPLAY: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
                else advance = 1'b1;
            default: state_d = IDLE;
        endcase
        if (advance) begin
            row_ptr_d = wrap ? '0 : row_ptr_q + 1'b1;
            frame_done_d = wrap;
            state_d = enable_in ? FETCH : IDLE;
        end
        // oe_n is a flop decoded from the next state so the panel enable never glitches
        oe_n_d = state_d != DISPLAY;
    end
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            row_ptr_q <= '0;
            row_addr_q <= '0;
            cnt_q <= '0;
            row_buf_q <= '0;
            oe_n_q <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_ptr_q <= row_ptr_d;
            row_addr_q <= row_addr_d;
            cnt_q <= cnt_d;
            row_buf_q <= row_buf_d;
            oe_n_q <= oe_n_d;
            frame_done_q <= frame_done_d;
        end
    end
    // row_ptr only moves on row advance, so it doubles as the held read address
    assign fb_rd_req_out = state_q == FETCH;
    assign fb_rd_addr_out = row_ptr_q;
    assign row_valid_out = state_q == SEND && row_ready_in;
    assign row_out = row_buf_q;
    assign row_addr_out = row_addr_q;
    assign oe_n_out = oe_n_q;
    assign frame_done_out = frame_done_q;
endmodule

// File: tb/tb_led_display_row_scheduler.sv
// tb_led_display_row_scheduler: randomized row-level scenarios checked against a per-row transaction model.
module tb_led_display_row_scheduler;
    localparam int BC = 4;
    logic clk_in, reset_in, enable_in, fb_rd_valid_in, row_ready_in, latch_in;
    logic [7:0] brightness_in;
    logic [383:0] fb_rd_data_in, row_out, last_data;
    logic fb_rd_req_out, row_valid_out, oe_n_out, frame_done_out;
    logic [3:0] fb_rd_addr_out, row_addr_out;
    int checks, errors, exp_row;

    led_display_row_scheduler dut (
        .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in), .brightness_in(brightness_in),
        .fb_rd_req_out(fb_rd_req_out), .fb_rd_addr_out(fb_rd_addr_out), .fb_rd_valid_in(fb_rd_valid_in),
        .fb_rd_data_in(fb_rd_data_in), .row_valid_out(row_valid_out), .row_out(row_out),
        .row_ready_in(row_ready_in), .latch_in(latch_in), .row_addr_out(row_addr_out),
        .oe_n_out(oe_n_out), .frame_done_out(frame_done_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] rnd_row();
        logic [383:0] r;
        for (int k = 0; k < 12; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_reset(input logic [383:0] buf_exp);
        chk("rst_req", fb_rd_req_out, 0);
        chk("rst_fb_addr", fb_rd_addr_out, 0);
        chk("rst_row_valid", row_valid_out, 0);
        chk("rst_frame_done", frame_done_out, 0);
        chk("rst_oe_n", oe_n_out, 1);
        chk("rst_row_addr", row_addr_out, 0);
        chk("rst_row_out", row_out, buf_exp);
    endtask

    // Called in the FETCH cycle of row exp_row; returns in the first cycle of the following row (or after reset).
    task automatic do_row(input int lat, input int rdy_wait, input int latch_wait, input int bright,
                          input bit en_after, input bit rst_mid);
        logic [383:0] d;
        d = rnd_row();
        chk("req", fb_rd_req_out, 1);
        chk("req_addr", fb_rd_addr_out, 384'(exp_row));
        chk("oe_fetch", oe_n_out, 1);
        for (int i = 1; i <= lat; i++) begin
            step();
            fb_rd_valid_in = (i == lat);
            fb_rd_data_in = (i == lat) ? d : rnd_row();
            latch_in = 1'($urandom % 2);
            #1;
            chk("req_once", fb_rd_req_out, 0);
            chk("addr_held", fb_rd_addr_out, 384'(exp_row));
            if (i == 1) chk("fd_single", frame_done_out, 0);
        end
        step();
        fb_rd_valid_in = 1'b0;
        fb_rd_data_in = rnd_row();
        latch_in = 1'b0;
        for (int w = 0; w < rdy_wait; w++) begin
            row_ready_in = 1'b0;
            #1;
            chk("strobe_hold", row_valid_out, 0);
            step();
        end
        row_ready_in = 1'b1;
        #1;
        chk("strobe", row_valid_out, 1);
        chk("row_data", row_out, d);
        last_data = d;
        for (int w = 0; w < latch_wait; w++) begin
            step();
            enable_in = en_after;
            fb_rd_valid_in = 1'($urandom % 2);
            #1;
            chk("strobe_once", row_valid_out, 0);
            chk("oe_wait_latch", oe_n_out, 1);
        end
        step();
        latch_in = 1'b1;
        fb_rd_valid_in = 1'b0;
        #1;
        chk("row_buf_kept", row_out, d);
        for (int b = 0; b < BC; b++) begin
            step();
            latch_in = 1'($urandom % 2);
            fb_rd_valid_in = 1'($urandom % 2);
            brightness_in = (b == BC - 1) ? 8'(bright) : 8'($urandom);
            #1;
            chk("oe_blank", oe_n_out, 1);
            chk("row_addr", row_addr_out, 384'(exp_row));
            chk("fd_blank", frame_done_out, 0);
        end
        for (int k = 0; k < bright; k++) begin
            step();
            latch_in = 1'b0;
            fb_rd_valid_in = 1'b0;
            brightness_in = 8'($urandom);
            if (rst_mid && k == 2) reset_in = 1'b1;
            #1;
            chk("oe_display", oe_n_out, 0);
            if (rst_mid && k == 2) begin
                step();
                reset_in = 1'b0;
                enable_in = 1'b0;
                #1;
                chk_reset('0);
                return;
            end
        end
        step();
        latch_in = 1'b0;
        fb_rd_valid_in = 1'b0;
        #1;
        chk("oe_after", oe_n_out, 1);
        chk("frame_done", frame_done_out, 384'(exp_row == 15));
        exp_row = (exp_row + 1) % 16;
        chk("next_req", fb_rd_req_out, 384'(en_after));
        chk("next_addr", fb_rd_addr_out, 384'(exp_row));
    endtask

    task automatic rand_row(input int bright);
        do_row($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(1, 6), bright, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_row = 0;
        reset_in = 1'b1;
        enable_in = 1'b0;
        brightness_in = 8'd0;
        fb_rd_valid_in = 1'b0;
        fb_rd_data_in = '0;
        row_ready_in = 1'b1;
        latch_in = 1'b0;
        repeat (3) step();
        #1;
        chk_reset('0);
        step();
        reset_in = 1'b0;
        enable_in = 1'b1;
        #1;
        chk("idle_no_req", fb_rd_req_out, 0);
        step();
        #1;
        do_row(3, 0, 64, $urandom_range(1, 20), 1'b1, 1'b0);
        for (int r = 1; r < 16; r++) rand_row(10);
        do_row(2, 20, 3, 5, 1'b1, 1'b0);
        for (int r = 1; r < 16; r++) rand_row(0);
        do_row($urandom_range(1, 5), 1, 2, $urandom_range(1, 8), 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            step();
            row_ready_in = 1'b1;
            latch_in = 1'($urandom % 2);
            fb_rd_valid_in = 1'b1;
            fb_rd_data_in = rnd_row();
            #1;
            chk("idle_req", fb_rd_req_out, 0);
            chk("idle_strobe", row_valid_out, 0);
            chk("idle_oe", oe_n_out, 1);
            chk("idle_row_out", row_out, last_data);
        end
        step();
        fb_rd_valid_in = 1'b0;
        latch_in = 1'b0;
        enable_in = 1'b1;
        #1;
        chk("idle_req_en", fb_rd_req_out, 0);
        step();
        #1;
        for (int r = 1; r < 7; r++) rand_row($urandom_range(0, 12));
        do_row(2, 1, 3, 8, 1'b1, 1'b1);
        exp_row = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            latch_in = 1'b1;
            fb_rd_valid_in = 1'b1;
            fb_rd_data_in = rnd_row();
            #1;
            chk_reset('0);
        end
        step();
        latch_in = 1'b0;
        fb_rd_valid_in = 1'b0;
        enable_in = 1'b1;
        #1;
        step();
        #1;
        for (int r = 0; r < 3; r++) rand_row($urandom_range(1, 6));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_display_row_scheduler.md
LED_DISPLAY_ROW_SCHEDULER -- requirements
Module: led_display_row_scheduler

Interface
REQ-001 Parameter NUM_ROW_ADDR, 16, number of row-pair addresses per frame (upper and lower half scanned together).
REQ-002 Parameter ROW_ADDR_W, $clog2(NUM_ROW_ADDR), width of row address.
REQ-003 Parameter BLANK_CYCLES, 4, oe_n_out high time (clk_in cycles, >=1) after each latch.
REQ-004 One clock, clk_in; reset is synchronous and active-high, reset_in.
REQ-005 clk_in  in  1  module clock.
REQ-006 reset_in  in  1  synchronous active-high reset.
REQ-007 enable_in  in  1  scan enable; level sensitive.
REQ-008 brightness_in  in  8  DISPLAY on-time in cycles, sampled on BLANK exit.
REQ-009 fb_rd_req_out  out  1  one-cycle frame-buffer read request.
REQ-010 fb_rd_addr_out  out  ROW_ADDR_W  row address of the request; held until data returns.
REQ-011 fb_rd_valid_in  in  1  read data valid (any latency >=1 cycle).
REQ-012 fb_rd_data_in  in  rgb_row_t  returned row pair.
REQ-013 row_valid_out  out  1  row strobe to shift driver.
REQ-014 row_out  out  rgb_row_t  buffered row to shift driver.
REQ-015 row_ready_in  in  1  shift driver idle.
REQ-016 latch_in  in  1  one-cycle latch pulse from shift driver.
REQ-017 row_addr_out  out  ROW_ADDR_W  panel A/B/C/D address lines.
REQ-018 oe_n_out  out  1  panel output enable, active low.
REQ-019 frame_done_out  out  1  one-cycle pulse after last row's DISPLAY ends.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT_DATA, SEND, WAIT_LATCH, BLANK, DISPLAY.
REQ-021 IDLE: enable_in=1 -> FETCH next cycle; else remain.
REQ-022 FETCH: fb_rd_req_out=1 for exactly one cycle with fb_rd_addr_out=row_ptr; -> WAIT_DATA.
REQ-023 WAIT_DATA: on fb_rd_valid_in=1 capture fb_rd_data_in into row buffer -> SEND; fb_rd_valid_in in any other state ignored.
REQ-024 SEND: row_valid_out=1 for exactly the one cycle in SEND where row_ready_in=1, then -> WAIT_LATCH; row_ready_in=0 holds SEND with row_valid_out=0.
REQ-025 row_out SHALL equal the row buffer at all times; buffer changes only on WAIT_DATA capture.
REQ-026 WAIT_LATCH: on latch_in=1 -> BLANK, row_addr_out<=row_ptr on same edge, blank counter<=BLANK_CYCLES-1; latch_in outside WAIT_LATCH ignored.
REQ-027 oe_n_out SHALL be 0 only in DISPLAY; 1 in all other states (registered, no glitch).
REQ-028 BLANK: decrement counter; at 0 sample brightness_in: nonzero -> DISPLAY with counter<=brightness_in-1; zero -> row advance (REQ-030) skipping DISPLAY.
REQ-029 DISPLAY: decrement counter; at 0 -> row advance; on-time exactly brightness_in cycles.
REQ-030 Row advance: row_ptr<=row_ptr+1, wrapping NUM_ROW_ADDR-1 -> 0; on wrap frame_done_out=1 for one cycle; next state FETCH if enable_in=1 else IDLE.
REQ-031 enable_in deassert mid-row SHALL NOT abort; current row completes through row advance, then IDLE.
REQ-032 brightness_in changes outside BLANK exit cycle SHALL not affect the current DISPLAY.
REQ-033 Exactly one fb_rd_req_out and one row_valid_out per row; no outstanding request in IDLE.

Reset
REQ-034 reset_in=1 at any edge, including mid-row: state IDLE, row_ptr=0, counters=0, row buffer=0, row_addr_out=0, oe_n_out=1, fb_rd_req_out=0, fb_rd_addr_out=0, row_valid_out=0, frame_done_out=0.
REQ-035 Responses (fb_rd_valid_in, latch_in) arriving after reset SHALL be ignored until requested again.

Verification
REQ-036 Reset release, enable_in=1, fb latency 3, row_ready_in=1, latch 64 cycles after strobe -> req addr 0, strobe 4 cycles later, row_addr_out=0, oe_n high 4 cycles, low brightness_in cycles.
REQ-037 Full frame, brightness_in=10 -> addresses 0..15 in order, frame_done_out single pulse after row 15 DISPLAY, next req addr 0.
REQ-038 row_ready_in held 0 for 20 cycles in SEND -> row_valid_out stays 0, single one-cycle strobe when ready rises.
REQ-039 brightness_in=0 -> oe_n_out never low, rows still advance, frame_done_out still pulses.
REQ-040 enable_in dropped during WAIT_LATCH -> row completes, IDLE, no further fb_rd_req_out; spurious latch_in/fb_rd_valid_in in IDLE ignored.
REQ-041 reset_in pulsed during DISPLAY of row 7 -> next cycle all REQ-034 values; restart from address 0.
